// File: rtl/router_pkg.sv
// Router state encodings shared by the ingress controller, register block and synchronizer.
package router_pkg;

  localparam logic [3:0] ST_DECODE          = 4'd0;
  localparam logic [3:0] ST_WAIT_EMPTY      = 4'd1;
  localparam logic [3:0] ST_LOAD_FIRST      = 4'd2;
  localparam logic [3:0] ST_LOAD_DATA       = 4'd3;
  localparam logic [3:0] ST_LOAD_PARITY     = 4'd4;
  localparam logic [3:0] ST_FIFO_FULL       = 4'd5;
  localparam logic [3:0] ST_LOAD_AFTER_FULL = 4'd6;
  localparam logic [3:0] ST_CHECK_PARITY    = 4'd7;
  localparam logic [3:0] ST_DROP            = 4'd8;

  typedef enum logic [3:0] {
    DECODE          = ST_DECODE,
    WAIT_EMPTY      = ST_WAIT_EMPTY,
    LOAD_FIRST      = ST_LOAD_FIRST,
    LOAD_DATA       = ST_LOAD_DATA,
    LOAD_PARITY     = ST_LOAD_PARITY,
    FIFO_FULL       = ST_FIFO_FULL,
    LOAD_AFTER_FULL = ST_LOAD_AFTER_FULL,
    CHECK_PARITY    = ST_CHECK_PARITY,
    DROP            = ST_DROP
  } state_t;

endpackage

// File: rtl/router_fsm_nch.sv
// Router ingress controller: steers header/payload/parity of one packet into one of NUM_CH FIFOs.
// state           | meaning
// DECODE          | idle, header address sampled when pkt_vld
// WAIT_EMPTY      | destination FIFO not yet empty, timeout running
// LOAD_FIRST      | header byte written
// LOAD_DATA       | payload bytes written while pkt_vld
// LOAD_PARITY     | parity byte written
// CHECK_PARITY    | parity compare in register block
// FIFO_FULL       | destination full, source stalled
// LOAD_AFTER_FULL | byte held during full is written
// DROP            | illegal address or timeout, packet discarded
module router_fsm_nch
  import router_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int ADDR_W  = 2,
  parameter int TIMEOUT = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              pkt_vld,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic [NUM_CH-1:0] fifo_empty,
  input  logic [NUM_CH-1:0] soft_rst,
  input  logic              parity_done,
  input  logic              low_pkt_vld,
  output logic [ADDR_W-1:0] dest,
  output logic              busy,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              rst_int_reg,
  output logic              write_enb_reg,
  output logic              addr_err,
  output logic              wait_tmo
);

  localparam int CH_SPAN = 2 ** ADDR_W;
  localparam int CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST   = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
  localparam logic [ADDR_W:0]   NUM_CH_EXT = (ADDR_W + 1)'(NUM_CH);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [CH_SPAN-1:0] empty_ext;
  logic [CH_SPAN-1:0] srst_ext;
  logic               hdr_illegal;
  logic               srst_hit;

  // Widen per-channel flags so every address value indexes a defined bit.
  assign empty_ext   = CH_SPAN'(fifo_empty);
  assign srst_ext    = CH_SPAN'(soft_rst);
  assign hdr_illegal = {1'b0, data_in} >= NUM_CH_EXT;
  assign srst_hit    = (state != DECODE) && (state != DROP) && srst_ext[dest];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= DECODE;
      dest     <= '0;
      cnt      <= '0;
      addr_err <= 1'b0;
      wait_tmo <= 1'b0;
    end else begin
      addr_err <= 1'b0;
      wait_tmo <= 1'b0;
      if (srst_hit) begin
        state <= DECODE;
      end else begin
        case (state)
          DECODE: begin
            if (pkt_vld) begin
              dest <= data_in;
              if (hdr_illegal) begin
                state    <= DROP;
                addr_err <= 1'b1;
              end else if (empty_ext[data_in]) begin
                state <= LOAD_FIRST;
              end else begin
                state <= WAIT_EMPTY;
                cnt   <= '0;
              end
            end
          end
          WAIT_EMPTY: begin
            if (empty_ext[dest]) begin
              state <= LOAD_FIRST;
            end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
              state    <= DROP;
              wait_tmo <= 1'b1;
            end else if (cnt != CNT_MAX) begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          LOAD_FIRST: state <= LOAD_DATA;
          LOAD_DATA: begin
            if (fifo_full)     state <= FIFO_FULL;
            else if (!pkt_vld) state <= LOAD_PARITY;
          end
          LOAD_PARITY: state <= CHECK_PARITY;
          CHECK_PARITY: state <= fifo_full ? FIFO_FULL : DECODE;
          FIFO_FULL: begin
            if (!fifo_full) state <= LOAD_AFTER_FULL;
          end
          LOAD_AFTER_FULL: begin
            if (parity_done)      state <= DECODE;
            else if (low_pkt_vld) state <= LOAD_PARITY;
            else                  state <= LOAD_DATA;
          end
          DROP: begin
            if (!pkt_vld) state <= DECODE;
          end
          default: state <= DECODE;
        endcase
      end
    end
  end

  assign detect_add    = (state == DECODE);
  assign lfd_state     = (state == LOAD_FIRST);
  assign ld_state      = (state == LOAD_DATA);
  assign laf_state     = (state == LOAD_AFTER_FULL);
  assign full_state    = (state == FIFO_FULL);
  assign rst_int_reg   = (state == CHECK_PARITY);
  assign write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) ||
                         (state == LOAD_AFTER_FULL);
  assign busy          = (state == LOAD_FIRST) || (state == LOAD_PARITY) ||
                         (state == CHECK_PARITY) || (state == FIFO_FULL) ||
                         (state == LOAD_AFTER_FULL) || (state == WAIT_EMPTY);

endmodule

// File: tb/tb_router_fsm_nch.sv
// Scoreboard bench for router_fsm_nch (NUM_CH=3, ADDR_W=2, TIMEOUT=12).
module tb_router_fsm_nch;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       pkt_vld = 1'b0;
  logic [1:0] data_in = '0;
  logic       fifo_full = 1'b0;
  logic [2:0] fifo_empty = 3'b111;
  logic [2:0] soft_rst = '0;
  logic       parity_done = 1'b0;
  logic       low_pkt_vld = 1'b0;
  logic [1:0] dest;
  logic       busy, detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       rst_int_reg, write_enb_reg, addr_err, wait_tmo;

  router_fsm_nch #(.NUM_CH(3), .ADDR_W(2), .TIMEOUT(12)) dut (
    .clk(clk), .rstn(rstn), .pkt_vld(pkt_vld), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_rst(soft_rst),
    .parity_done(parity_done), .low_pkt_vld(low_pkt_vld), .dest(dest),
    .busy(busy), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .write_enb_reg(write_enb_reg),
    .addr_err(addr_err), .wait_tmo(wait_tmo)
  );

  always #5 clk = ~clk;

  // {detect_add, lfd, ld, laf, full, rst_int, write_enb, busy}
  localparam logic [7:0] O_DEC  = 8'b1000_0000;
  localparam logic [7:0] O_WAIT = 8'b0000_0001;
  localparam logic [7:0] O_LFD  = 8'b0100_0001;
  localparam logic [7:0] O_LD   = 8'b0010_0010;
  localparam logic [7:0] O_LP   = 8'b0000_0011;
  localparam logic [7:0] O_CP   = 8'b0000_0101;
  localparam logic [7:0] O_FULL = 8'b0000_1001;
  localparam logic [7:0] O_LAF  = 8'b0001_0011;
  localparam logic [7:0] O_DROP = 8'b0000_0000;

  typedef logic [11:0] vec_t;
  vec_t exp_q[$];
  vec_t obs;
  int   n_vec = 0;
  int   n_err = 0;

  assign obs = {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
                write_enb_reg, busy, addr_err, wait_tmo, dest};

  task automatic tick(input logic [7:0] st, input logic ae, input logic wt, input logic [1:0] d);
    exp_q.push_back({st, ae, wt, d});
    @(negedge clk);
  endtask

  task automatic check_now(input string name, input vec_t e);
    n_vec++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, obs, e);
    end
  endtask

  initial begin : monitor
    vec_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (obs !== e) begin
          n_err++;
          $display("FAIL cycle_vec%0d: got %b expected %b (t=%0t)", n_vec, obs, e, $time);
        end
      end
    end
  end

  initial begin : stimulus
    #1;
    check_now("reset_state", {O_DEC, 1'b0, 1'b0, 2'd0});
    @(negedge clk);
    rstn = 1'b1;

    // basic packet to channel 2; data_in changes after header must not move dest
    pkt_vld = 1; data_in = 2;
    tick(O_LFD, 0, 0, 2);
    data_in = 0;
    tick(O_LD, 0, 0, 2);
    repeat (3) tick(O_LD, 0, 0, 2);
    pkt_vld = 0;
    tick(O_LP, 0, 0, 2);
    tick(O_CP, 0, 0, 2);
    tick(O_DEC, 0, 0, 2);

    // wait 10 cycles for channel 1 to drain, no timeout
    fifo_empty = 3'b101; pkt_vld = 1; data_in = 1;
    repeat (10) tick(O_WAIT, 0, 0, 1);
    fifo_empty = 3'b111;
    tick(O_LFD, 0, 0, 1);
    pkt_vld = 0;
    tick(O_LD, 0, 0, 1);
    tick(O_LP, 0, 0, 1);
    tick(O_CP, 0, 0, 1);
    tick(O_DEC, 0, 0, 1);

    // channel 2 stuck non-empty: timeout after 12 wait cycles
    fifo_empty = 3'b011; pkt_vld = 1; data_in = 2;
    repeat (12) tick(O_WAIT, 0, 0, 2);
    tick(O_DROP, 0, 1, 2);
    tick(O_DROP, 0, 0, 2);
    pkt_vld = 0;
    tick(O_DEC, 0, 0, 2);

    // empty arriving on the last wait cycle beats the timeout
    fifo_empty = 3'b110; pkt_vld = 1; data_in = 0;
    repeat (12) tick(O_WAIT, 0, 0, 0);
    fifo_empty = 3'b111;
    tick(O_LFD, 0, 0, 0);
    pkt_vld = 0;
    tick(O_LD, 0, 0, 0);
    tick(O_LP, 0, 0, 0);
    tick(O_CP, 0, 0, 0);
    tick(O_DEC, 0, 0, 0);

    // illegal address 3 with NUM_CH=3
    pkt_vld = 1; data_in = 3;
    tick(O_DROP, 1, 0, 3);
    tick(O_DROP, 0, 0, 3);
    pkt_vld = 0;
    tick(O_DEC, 0, 0, 3);

    // full for 5 cycles, released with low_pkt_vld
    pkt_vld = 1; data_in = 0;
    tick(O_LFD, 0, 0, 0);
    tick(O_LD, 0, 0, 0);
    tick(O_LD, 0, 0, 0);
    fifo_full = 1;
    repeat (5) tick(O_FULL, 0, 0, 0);
    fifo_full = 0; low_pkt_vld = 1;
    tick(O_LAF, 0, 0, 0);
    tick(O_LP, 0, 0, 0);
    low_pkt_vld = 0; pkt_vld = 0;
    tick(O_CP, 0, 0, 0);
    tick(O_DEC, 0, 0, 0);

    // full seen in CHECK_PARITY, then parity_done exit from LOAD_AFTER_FULL
    pkt_vld = 1; data_in = 2;
    tick(O_LFD, 0, 0, 2);
    pkt_vld = 0;
    tick(O_LD, 0, 0, 2);
    tick(O_LP, 0, 0, 2);
    fifo_full = 1;
    tick(O_CP, 0, 0, 2);
    tick(O_FULL, 0, 0, 2);
    fifo_full = 0;
    tick(O_LAF, 0, 0, 2);
    parity_done = 1;
    tick(O_DEC, 0, 0, 2);
    parity_done = 0;

    // LOAD_AFTER_FULL back to LOAD_DATA, then soft reset other/own channel
    pkt_vld = 1; data_in = 1;
    tick(O_LFD, 0, 0, 1);
    tick(O_LD, 0, 0, 1);
    fifo_full = 1;
    tick(O_FULL, 0, 0, 1);
    fifo_full = 0;
    tick(O_LAF, 0, 0, 1);
    tick(O_LD, 0, 0, 1);
    fifo_full = 1;
    tick(O_FULL, 0, 0, 1);
    soft_rst = 3'b001;
    tick(O_FULL, 0, 0, 1);
    soft_rst = 3'b010; pkt_vld = 0;
    tick(O_DEC, 0, 0, 1);
    soft_rst = 3'b000; fifo_full = 0;

    // asynchronous reset in the middle of LOAD_DATA
    pkt_vld = 1; data_in = 2;
    tick(O_LFD, 0, 0, 2);
    tick(O_LD, 0, 0, 2);
    rstn = 0;
    #1;
    check_now("async_reset", {O_DEC, 1'b0, 1'b0, 2'd0});
    @(negedge clk);
    rstn = 1; pkt_vld = 0;
    tick(O_DEC, 0, 0, 0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d entries left expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
